// File: rtl/ed_sensing_scheduler.sv
// rtl/ed_sensing_scheduler.sv - sensing-window sequencer for the energy-detection chain
// Optional build macro: ED_SCHED_STATUS_EN adds the status port and the dropped-strobe counter.
module ed_sensing_scheduler #(
    parameter int FFT_LEN      = 1024,
    parameter int FLUSH_CYCLES = 16,
    parameter int ADDR_BASE    = 8,
    parameter int DRAIN_TMO    = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        strobe_in,
    input  logic        dv_out_chain,
    output logic        strobe_gated,
    output logic        pipe_clear,
    output logic        busy,
    output logic        window_done,
    output logic        drain_err,
`ifdef ED_SCHED_STATUS_EN
    output logic [31:0] status,
`endif
    output logic [15:0] window_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_SENSE = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sense_frames_q, sense_frames_d;
    logic [31:0] idle_cycles_q, idle_cycles_d;
    logic        enable_q, enable_d;
    logic        continuous_q, continuous_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;
    logic [31:0] tmr_q, tmr_d;
    logic [31:0] in_cnt_q, in_cnt_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic [31:0] target_q, target_d;
    logic [31:0] idle_lat_q, idle_lat_d;
    logic        window_done_q, window_done_d;
    logic        drain_err_q, drain_err_d;
    logic [15:0] window_cnt_q, window_cnt_d;
`ifdef ED_SCHED_STATUS_EN
    logic        stat_sel_q, stat_sel_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

    logic        wr_sf, wr_idle, wr_ctrl, clr_err;
    logic        admit;
    logic        go_flush;
    logic        drain_exit;
    logic [15:0] sf_eff;

    assign wr_sf   = set_stb && (set_addr == 8'(ADDR_BASE));
    assign wr_idle = set_stb && (set_addr == 8'(ADDR_BASE + 1));
    assign wr_ctrl = set_stb && (set_addr == 8'(ADDR_BASE + 2));
    assign clr_err = wr_ctrl && set_data[3];
    assign sf_eff  = (sense_frames_q == 16'd0) ? 16'd1 : sense_frames_q;

    // Admission also depends on enable_q so an abort gates strobes the cycle the write lands.
    assign admit        = (state_q == S_SENSE) && enable_q && (in_cnt_q < target_q);
    assign strobe_gated = strobe_in && admit;
    assign pipe_clear   = (state_q == S_FLUSH);
    assign busy         = (state_q != S_IDLE);
    assign window_done  = window_done_q;
    assign drain_err    = drain_err_q;
    assign window_cnt   = window_cnt_q;

    always_comb begin
        sense_frames_d = sense_frames_q;
        idle_cycles_d  = idle_cycles_q;
        enable_d       = enable_q;
        continuous_d   = continuous_q;
        start_d        = 1'b0;
`ifdef ED_SCHED_STATUS_EN
        stat_sel_d     = stat_sel_q;
`endif
        if (wr_sf)   sense_frames_d = set_data[15:0];
        if (wr_idle) idle_cycles_d  = set_data;
        if (wr_ctrl) begin
            enable_d     = set_data[0];
            continuous_d = set_data[1];
            start_d      = set_data[2] && set_data[0];
`ifdef ED_SCHED_STATUS_EN
            stat_sel_d   = set_data[4];
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        abort_d       = abort_q;
        tmr_d         = tmr_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        target_d      = target_q;
        idle_lat_d    = idle_lat_q;
        window_done_d = 1'b0;
        window_cnt_d  = window_cnt_q;
        drain_err_d   = clr_err ? 1'b0 : drain_err_q;
        go_flush      = 1'b0;
        drain_exit    = 1'b0;

        if (strobe_gated)
            in_cnt_d = in_cnt_q + 32'd1;
        if (((state_q == S_SENSE) || (state_q == S_DRAIN)) && dv_out_chain && (out_cnt_q != 32'hFFFF_FFFF))
            out_cnt_d = out_cnt_q + 32'd1;

        if (state_q == S_IDLE) begin
            if (start_q && enable_q)
                go_flush = 1'b1;
        end else if (!enable_q && !abort_q) begin
            go_flush = 1'b1;
            abort_d  = 1'b1;
        end else begin
            case (state_q)
                S_FLUSH: begin
                    in_cnt_d  = 32'd0;
                    out_cnt_d = 32'd0;
                    if (tmr_q == 32'(FLUSH_CYCLES - 1)) begin
                        state_d = abort_q ? S_IDLE : S_SENSE;
                        abort_d = 1'b0;
                        tmr_d   = 32'd0;
                    end else begin
                        tmr_d = tmr_q + 32'd1;
                    end
                end
                S_SENSE: begin
                    if (in_cnt_d >= target_q) begin
                        state_d = S_DRAIN;
                        tmr_d   = 32'd0;
                    end
                end
                S_DRAIN: begin
                    if (out_cnt_d >= target_q) begin
                        drain_exit = 1'b1;
                    end else if (tmr_q == 32'(DRAIN_TMO - 1)) begin
                        drain_exit  = 1'b1;
                        drain_err_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 32'd1;
                    end
                end
                S_GAP: begin
                    // IDLE_CYCLES of 0 or 1 both give a single GAP cycle.
                    if (({1'b0, tmr_q} + 33'd1) >= {1'b0, idle_lat_q}) begin
                        if (continuous_q && enable_q)
                            go_flush = 1'b1;
                        else
                            state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q + 32'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (drain_exit) begin
            state_d       = S_GAP;
            tmr_d         = 32'd0;
            window_done_d = 1'b1;
            window_cnt_d  = window_cnt_q + 16'd1;
        end

        // Window geometry is captured only here, so mid-window writes apply to the next window.
        if (go_flush) begin
            state_d    = S_FLUSH;
            tmr_d      = 32'd0;
            target_d   = 32'(sf_eff) * 32'(FFT_LEN);
            idle_lat_d = idle_cycles_q;
        end
    end

`ifdef ED_SCHED_STATUS_EN
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (strobe_in && ((state_q == S_FLUSH) || (state_q == S_DRAIN) || (state_q == S_GAP))
            && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    assign status = stat_sel_q ? {16'h0000, drop_cnt_q}
                               : {state_q, drain_err_q, 12'h000, window_cnt_q};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            sense_frames_q <= 16'd0;
            idle_cycles_q  <= 32'd0;
            enable_q       <= 1'b0;
            continuous_q   <= 1'b0;
            start_q        <= 1'b0;
            abort_q        <= 1'b0;
            tmr_q          <= 32'd0;
            in_cnt_q       <= 32'd0;
            out_cnt_q      <= 32'd0;
            target_q       <= 32'd0;
            idle_lat_q     <= 32'd0;
            window_done_q  <= 1'b0;
            drain_err_q    <= 1'b0;
            window_cnt_q   <= 16'd0;
`ifdef ED_SCHED_STATUS_EN
            stat_sel_q     <= 1'b0;
            drop_cnt_q     <= 16'd0;
`endif
        end else begin
            state_q        <= state_d;
            sense_frames_q <= sense_frames_d;
            idle_cycles_q  <= idle_cycles_d;
            enable_q       <= enable_d;
            continuous_q   <= continuous_d;
            start_q        <= start_d;
            abort_q        <= abort_d;
            tmr_q          <= tmr_d;
            in_cnt_q       <= in_cnt_d;
            out_cnt_q      <= out_cnt_d;
            target_q       <= target_d;
            idle_lat_q     <= idle_lat_d;
            window_done_q  <= window_done_d;
            drain_err_q    <= drain_err_d;
            window_cnt_q   <= window_cnt_d;
`ifdef ED_SCHED_STATUS_EN
            stat_sel_q     <= stat_sel_d;
            drop_cnt_q     <= drop_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ed_sensing_scheduler.sv
// tb/tb_ed_sensing_scheduler.sv - directed self-checking bench for ed_sensing_scheduler
module tb_ed_sensing_scheduler;

    localparam int AB = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic        strobe_in = 1'b0;
    logic        dv_out_chain;
    logic        strobe_gated, pipe_clear, busy, window_done, drain_err;
    logic [15:0] window_cnt;

    logic        dv_en = 1'b0;
    logic [4:0]  dv_pipe = 5'd0;

    int cyc_n = 0, gated_tot = 0, clr_tot = 0, done_tot = 0;
    int last_gated = 0, last_done = 0, prev_done = 0;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [15:0] sf;
        logic        dv;
        int          exp_gated;
        int          exp_delta;
        logic        exp_err;
    } vec_t;

    vec_t vecs[4];

    ed_sensing_scheduler #(
        .FFT_LEN(8), .FLUSH_CYCLES(16), .ADDR_BASE(AB), .DRAIN_TMO(100)
    ) dut (
        .clock(clock), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .strobe_in(strobe_in), .dv_out_chain(dv_out_chain),
        .strobe_gated(strobe_gated), .pipe_clear(pipe_clear), .busy(busy),
        .window_done(window_done), .drain_err(drain_err), .window_cnt(window_cnt)
    );

    always #5 clock = ~clock;

    assign dv_out_chain = dv_pipe[4];

    always @(posedge clock) dv_pipe <= {dv_pipe[3:0], strobe_gated & dv_en};

    always @(negedge clock) begin
        cyc_n <= cyc_n + 1;
        if (strobe_gated) begin
            gated_tot  <= gated_tot + 1;
            last_gated <= cyc_n;
        end
        if (pipe_clear) clr_tot <= clr_tot + 1;
        if (window_done) begin
            done_tot  <= done_tot + 1;
            last_done <= cyc_n;
            prev_done <= last_done;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cyc();
        set_stb = 1'b1; set_addr = a; set_data = d;
        cyc();
        set_stb = 1'b0;
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_tot;
        int i = 0;
        while (done_tot == d0 && i < budget) begin cyc(); i++; end
        if (done_tot == d0) bound_fail(name);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while (busy && i < budget) begin cyc(); i++; end
        if (busy) bound_fail(name);
    endtask

    task automatic wait_gated(input string name, input int n, input int budget);
        int g0 = gated_tot;
        int i = 0;
        while ((gated_tot - g0) < n && i < budget) begin cyc(); i++; end
        if ((gated_tot - g0) < n) bound_fail(name);
    endtask

    initial begin
        int exp_wcnt;
        int g0, c0, d0;

        vecs[0] = '{sf: 16'd2, dv: 1'b1, exp_gated: 16, exp_delta: 6,   exp_err: 1'b0};
        vecs[1] = '{sf: 16'd0, dv: 1'b1, exp_gated: 8,  exp_delta: 6,   exp_err: 1'b0};
        vecs[2] = '{sf: 16'd1, dv: 1'b0, exp_gated: 8,  exp_delta: 101, exp_err: 1'b1};
        vecs[3] = '{sf: 16'd3, dv: 1'b1, exp_gated: 24, exp_delta: 6,   exp_err: 1'b0};

        strobe_in = 1'b1;
        repeat (3) cyc();
        chk("rst_gated", {31'd0, strobe_gated}, 32'd0);
        chk("rst_clear", {31'd0, pipe_clear}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wcnt", {16'd0, window_cnt}, 32'd0);
        reset = 1'b1;
        repeat (5) cyc();
        chk("no_start_busy", {31'd0, busy}, 32'd0);

        exp_wcnt = 0;
        wr(AB + 1, 32'd0);
        for (int k = 0; k < 4; k++) begin
            wr(AB, {16'd0, vecs[k].sf});
            wr(AB + 2, 32'h9);
            chk($sformatf("v%0d_err_clr", k), {31'd0, drain_err}, 32'd0);
            dv_en = vecs[k].dv;
            g0 = gated_tot; c0 = clr_tot;
            wr(AB + 2, 32'h5);
            wait_done($sformatf("v%0d_done", k), 400);
            exp_wcnt++;
            chk($sformatf("v%0d_gated", k), 32'(gated_tot - g0), 32'(vecs[k].exp_gated));
            chk($sformatf("v%0d_delta", k), 32'(last_done - last_gated), 32'(vecs[k].exp_delta));
            chk($sformatf("v%0d_err", k), {31'd0, drain_err}, {31'd0, vecs[k].exp_err});
            chk($sformatf("v%0d_wcnt", k), {16'd0, window_cnt}, 32'(exp_wcnt));
            repeat (3) cyc();
            chk($sformatf("v%0d_idle", k), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_clear", k), 32'(clr_tot - c0), 32'd16);
        end

        dv_en = 1'b1;
        wr(AB, 32'd2);
        wr(AB + 1, 32'd10);
        wr(AB + 2, 32'h7);
        wait_done("cont_w1", 400);
        wait_done("cont_w2", 400);
        chk("cont_period1", 32'(last_done - prev_done), 32'd47);
        wait_done("cont_w3", 400);
        chk("cont_period2", 32'(last_done - prev_done), 32'd47);
        exp_wcnt += 3;
        chk("cont_wcnt", {16'd0, window_cnt}, 32'(exp_wcnt));
        c0 = clr_tot; d0 = done_tot;
        wr(AB + 2, 32'h0);
        wait_idle("cont_stop", 200);
        chk("cont_stop_clear", 32'(clr_tot - c0), 32'd16);
        chk("cont_stop_wcnt", {16'd0, window_cnt}, 32'(exp_wcnt));
        chk("cont_stop_done", 32'(done_tot - d0), 32'd0);

        wr(AB + 1, 32'd0);
        wr(AB + 2, 32'h5);
        wait_gated("abort_reach", 4, 200);
        c0 = clr_tot; d0 = done_tot;
        wr(AB + 2, 32'h0);
        chk("abort_gated_off", {31'd0, strobe_gated}, 32'd0);
        wait_idle("abort_idle", 200);
        chk("abort_clear", 32'(clr_tot - c0), 32'd16);
        chk("abort_wcnt", {16'd0, window_cnt}, 32'(exp_wcnt));
        chk("abort_done", 32'(done_tot - d0), 32'd0);

        wr(AB + 2, 32'h5);
        wait_gated("rst_reach", 3, 200);
        reset = 1'b0;
        #1;
        chk("mid_rst_gated", {31'd0, strobe_gated}, 32'd0);
        chk("mid_rst_clear", {31'd0, pipe_clear}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, window_done}, 32'd0);
        chk("mid_rst_err", {31'd0, drain_err}, 32'd0);
        chk("mid_rst_wcnt", {16'd0, window_cnt}, 32'd0);
        repeat (2) cyc();
        reset = 1'b1;
        g0 = gated_tot;
        repeat (20) cyc();
        chk("post_rst_gated", 32'(gated_tot - g0), 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        g0 = gated_tot;
        wr(AB + 2, 32'h5);
        wait_done("post_rst_done", 400);
        chk("post_rst_sf0_gated", 32'(gated_tot - g0), 32'd8);
        chk("post_rst_wcnt", {16'd0, window_cnt}, 32'd1);

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
